output_merge_controller: RTL and testbench

// Reverse end of the router's input-side splitter. Merges two req/ready source

---
 rtl/router_pkg.sv | 19 +
 rtl/output_merge_controller_rr_arb2.sv | 22 ++
 rtl/output_merge_controller.sv | 107 ++++++++++
 tb/tb_output_merge_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router types: merge FSM state encoding and default word geometry.
// The input-side splitter imports the same package.
package router_pkg;

  localparam int ROUTER_NB       = 11;
  localparam int ROUTER_TAIL_BIT = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_0 = 2'd1,
    GRANT_1 = 2'd2
  } merge_state_t;

  // Map a port index onto its grant state.
  function automatic merge_state_t grant_state(input logic port);
    return port ? GRANT_1 : GRANT_0;
  endfunction

endpackage

// File: rtl/output_merge_controller_rr_arb2.sv
// Two-way round-robin arbiter. A lone request wins outright; on a tie the
// port that was NOT most recently released wins. Purely combinational.
module rr_arb2 (
  input  logic req_0,
  input  logic req_1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_port
);

  // Pick the winning port from the request pair and the last pointer.
  always_comb begin
    gnt_valid = req_0 | req_1;
    gnt_port  = 1'b0;
    if (req_0 && req_1) begin
      gnt_port = ~last;
    end else if (req_1) begin
      gnt_port = 1'b1;
    end
  end

endmodule

// File: rtl/output_merge_controller.sv
// Merges two source channels into one downstream FIFO write port with
// round-robin arbitration, optional packet lock and one registered output.
//
// Handshake: a word on port i moves on a posedge where req_i && ready_i are
// both high. ready_i depends only on the FSM state and almost_full, never on
// req_i, so a source may hold req_i high and wait. The accepted word appears
// on data_out with write high exactly one cycle later.
module output_merge_controller
  import router_pkg::*;
#(
  parameter int NB          = ROUTER_NB,
  parameter int TAIL_BIT    = ROUTER_TAIL_BIT,
  parameter int PACKET_MODE = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_0,
  input  logic [NB-1:0] data_in_0,
  output logic          ready_0,
  input  logic          req_1,
  input  logic [NB-1:0] data_in_1,
  output logic          ready_1,
  input  logic          almost_full,
  output logic          write,
  output logic [NB-1:0] data_out,
  output logic [1:0]    state_dbg
);

  merge_state_t  state_q, state_d;
  logic          last_q, last_d;
  logic          write_q;
  logic [NB-1:0] data_q;

  logic          gnt_valid, gnt_port;
  logic          cur_port, cur_req, oth_req, xfer, tail;
  logic [NB-1:0] cur_data;

  rr_arb2 u_arb (
    .req_0     (req_0),
    .req_1     (req_1),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  // State and round-robin pointer; reset drops any packet in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next state: arbitrate from IDLE, hold the grant until a tail transfers.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) state_d = grant_state(gnt_port);
      end
      GRANT_0, GRANT_1: begin
        if (xfer && tail) begin
          last_d = cur_port;
          if (oth_req)      state_d = grant_state(~cur_port);
          else if (cur_req) state_d = grant_state(cur_port);
          else              state_d = IDLE;
        end else if ((PACKET_MODE == 0) && !cur_req && oth_req) begin
          // Without packet lock an idle owner yields straight away.
          state_d = grant_state(~cur_port);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs and the muxed view of the granted port.
  always_comb begin
    ready_0  = (state_q == GRANT_0) && !almost_full;
    ready_1  = (state_q == GRANT_1) && !almost_full;
    cur_port = (state_q == GRANT_1);
    cur_req  = cur_port ? req_1 : req_0;
    oth_req  = cur_port ? req_0 : req_1;
    cur_data = cur_port ? data_in_1 : data_in_0;
    xfer     = (ready_0 && req_0) || (ready_1 && req_1);
    tail     = (PACKET_MODE == 0) || cur_data[TAIL_BIT];
  end

  // Registered FIFO write stage; data_out holds between writes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      write_q <= 1'b0;
      data_q  <= '0;
    end else begin
      write_q <= xfer;
      if (xfer) data_q <= cur_data;
    end
  end

  assign write     = write_q;
  assign data_out  = data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_output_merge_controller.sv
// Directed and randomised checks for output_merge_controller. Two instances
// share stimulus: dut runs with packet lock, dut_w with every word a tail.
module tb_output_merge_controller;
  import router_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_0, req_1, almost_full;
  logic [10:0] data_in_0, data_in_1;

  logic        ready_0, ready_1, write;
  logic [10:0] data_out;
  logic [1:0]  state_dbg;
  logic        w_ready_0, w_ready_1, w_write;
  logic [10:0] w_data_out;
  logic [1:0]  w_state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] exp_q[$];

  output_merge_controller #(.NB(11), .TAIL_BIT(10), .PACKET_MODE(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_0(req_0), .data_in_0(data_in_0), .ready_0(ready_0),
    .req_1(req_1), .data_in_1(data_in_1), .ready_1(ready_1),
    .almost_full(almost_full), .write(write), .data_out(data_out),
    .state_dbg(state_dbg)
  );

  output_merge_controller #(.NB(11), .TAIL_BIT(10), .PACKET_MODE(0)) dut_w (
    .clk(clk), .reset_n(reset_n),
    .req_0(req_0), .data_in_0(data_in_0), .ready_0(w_ready_0),
    .req_1(req_1), .data_in_1(data_in_1), .ready_1(w_ready_1),
    .almost_full(almost_full), .write(w_write), .data_out(w_data_out),
    .state_dbg(w_state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  // Driver and checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checks(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed state %0d expected state %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard pop: a write must be present and carry the oldest expected word.
  task automatic pop_check(input string tag, input logic w, input logic [10:0] d);
    check1({tag, "_write"}, w, 1'b1);
    check1({tag, "_queued"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) checkw({tag, "_data"}, d, exp_q.pop_front());
  endtask

  // Random-phase source and sink state
  logic [1:0]  s_req;
  logic [10:0] s_word [2];
  logic [8:0]  s_seq [2];
  logic [8:0]  o_seq [2];
  int          fifo_cnt;
  logic        open_v, open_p, x0, x1;
  logic [10:0] w_word;
  logic [10:0] d0, d1;

  initial begin
    reset_n = 1'b0; req_0 = 1'b0; req_1 = 1'b0; almost_full = 1'b0;
    data_in_0 = '0; data_in_1 = '0;

    // Reset held with a pending request, then first grant and transfer
    req_0 = 1'b1; data_in_0 = 11'h001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("rst_ready_0", ready_0, 1'b0);
      check1("rst_ready_1", ready_1, 1'b0);
      check1("rst_write", write, 1'b0);
    end
    checkw("rst_data_out", data_out, 11'h000);
    reset_n = 1'b1;
    tick();
    checks("grant_after_rst", state_dbg, GRANT_0);
    check1("grant_ready_0", ready_0, 1'b1);
    check1("grant_write", write, 1'b0);

    // Packet lock: port 1 raised mid-packet waits for the tail
    exp_q.push_back(11'h001);
    tick();
    pop_check("pkt_w0", write, data_out);
    data_in_0 = 11'h002; req_1 = 1'b1; data_in_1 = 11'h011;
    exp_q.push_back(11'h002);
    check1("pkt_lock_ready_1", ready_1, 1'b0);
    tick();
    pop_check("pkt_w1", write, data_out);
    data_in_0 = 11'h403;
    exp_q.push_back(11'h403);
    check1("pkt_lock_ready_1b", ready_1, 1'b0);
    tick();
    pop_check("pkt_w2", write, data_out);
    checks("pkt_handover", state_dbg, GRANT_1);
    req_0 = 1'b0;
    exp_q.push_back(11'h011);
    tick();
    pop_check("pkt_p1_w0", write, data_out);
    data_in_1 = 11'h412;
    exp_q.push_back(11'h412);
    tick();
    pop_check("pkt_p1_w1", write, data_out);
    req_1 = 1'b0;
    tick();
    check1("pkt_idle_write", write, 1'b0);
    checkw("pkt_idle_hold", data_out, 11'h412);
    checks("pkt_keep_grant", state_dbg, GRANT_1);

    // almost_full stall in GRANT_1 with a tail waiting and port 0 pending
    req_1 = 1'b1; data_in_1 = 11'h421; req_0 = 1'b1; data_in_0 = 11'h431;
    almost_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check1("af_ready_1", ready_1, 1'b0);
      tick();
      check1("af_write", write, 1'b0);
      checkw("af_hold", data_out, 11'h412);
      checks("af_state", state_dbg, GRANT_1);
    end
    almost_full = 1'b0;
    #1;
    check1("af_resume_ready_1", ready_1, 1'b1);
    exp_q.push_back(11'h421);
    tick();
    pop_check("af_resume", write, data_out);
    checks("af_handover", state_dbg, GRANT_0);
    req_1 = 1'b0;
    exp_q.push_back(11'h431);
    tick();
    pop_check("af_p0", write, data_out);
    req_0 = 1'b0;

    // Reset after word 2 of a 3-word packet
    req_0 = 1'b1; data_in_0 = 11'h051;
    exp_q.push_back(11'h051);
    tick();
    pop_check("mid_w0", write, data_out);
    data_in_0 = 11'h052;
    exp_q.push_back(11'h052);
    tick();
    pop_check("mid_w1", write, data_out);
    reset_n = 1'b0; data_in_0 = 11'h453; req_1 = 1'b1; data_in_1 = 11'h461;
    tick();
    checks("mid_rst_state", state_dbg, IDLE);
    check1("mid_rst_write", write, 1'b0);
    checkw("mid_rst_data", data_out, 11'h000);
    check1("mid_rst_ready_0", ready_0, 1'b0);
    check1("mid_rst_ready_1", ready_1, 1'b0);
    reset_n = 1'b1; req_0 = 1'b0;
    tick();
    checks("mid_new_grant", state_dbg, GRANT_1);
    exp_q.push_back(11'h461);
    tick();
    pop_check("mid_new_pkt", write, data_out);
    req_1 = 1'b0;

    // Word mode: both requesting gives strict alternation at full rate
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    d0 = 11'h0A0; d1 = 11'h0B0;
    req_0 = 1'b1; req_1 = 1'b1; data_in_0 = d0; data_in_1 = d1;
    tick();
    checks("wm_first_tie", w_state_dbg, GRANT_0);
    for (int k = 0; k < 8; k++) begin
      data_in_0 = d0; data_in_1 = d1;
      #1;
      check1("wm_ready", (k % 2 == 1) ? w_ready_1 : w_ready_0, 1'b1);
      exp_q.push_back((k % 2 == 1) ? d1 : d0);
      tick();
      pop_check("wm_alt", w_write, w_data_out);
      if (k % 2 == 1) d1 = d1 + 11'd1;
      else            d0 = d0 + 11'd1;
    end
    req_0 = 1'b0;
    tick();
    checks("wm_yield", w_state_dbg, GRANT_1);
    check1("wm_yield_write", w_write, 1'b0);
    req_1 = 1'b0;

    // Random traffic into a modelled FIFO with random drain
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    s_req = '0; s_seq[0] = '0; s_seq[1] = '0; o_seq[0] = '0; o_seq[1] = '0;
    s_word[0] = '0; s_word[1] = '0;
    fifo_cnt = 0; open_v = 1'b0; open_p = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!s_req[p] && $urandom_range(0, 1) == 1) begin
          s_req[p]  = 1'b1;
          s_word[p] = {1'($urandom_range(0, 2) == 0), 1'(p), s_seq[p]};
        end
      end
      req_0 = s_req[0]; data_in_0 = s_word[0];
      req_1 = s_req[1]; data_in_1 = s_word[1];
      almost_full = (DEPTH - fifo_cnt) < 2;
      #1;
      check1("rnd_ready_excl", ready_0 & ready_1, 1'b0);
      check1("rnd_af_block", almost_full & (ready_0 | ready_1), 1'b0);
      x0 = req_0 & ready_0;
      x1 = req_1 & ready_1;
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? x0 : x1) begin
          exp_q.push_back(s_word[p]);
          s_seq[p] = s_seq[p] + 9'd1;
          if (s_word[p][10]) s_req[p] = 1'b0;
          else s_word[p] = {1'($urandom_range(0, 2) == 0), 1'(p), s_seq[p]};
        end
      end
      tick();
      check1("rnd_write", write, exp_q.size() != 0);
      if (write && exp_q.size() != 0) begin
        w_word = exp_q.pop_front();
        checkw("rnd_data", data_out, w_word);
        check1("rnd_fifo_room", fifo_cnt < DEPTH, 1'b1);
        fifo_cnt++;
        checkw("rnd_port_order", {2'b00, data_out[8:0]}, {2'b00, o_seq[data_out[9]]});
        o_seq[data_out[9]] = o_seq[data_out[9]] + 9'd1;
        if (open_v) check1("rnd_no_interleave", data_out[9], open_p);
        open_v = !data_out[10];
        open_p = data_out[9];
      end
      if (fifo_cnt > 0 && $urandom_range(0, 1) == 1) fifo_cnt--;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
